// File: rtl/cpu_step_controller_pkg.sv
// Shared definitions for the 6502 softcore CPU step controller: run state
// encoding and the widths of the rate select and pulse counter.
package cpu_pkg;

  localparam int RATE_W   = 2;
  localparam int CE_CNT_W = 16;

  typedef enum logic {
    HALT = 1'b0,
    RUN  = 1'b1
  } run_state_t;

endpackage

// File: rtl/cpu_step_controller_if.sv
// Board-facing signal bundle of the CPU step controller: raw buttons and rate
// select in, clock-enable pulse, run flag and pulse count out.
interface cpu_step_controller_if;
  import cpu_pkg::*;

  logic                btn_mode_n;
  logic                btn_step_n;
  logic [RATE_W-1:0]   rate_sel;
  logic                cpu_ce;
  logic                running;
  logic [CE_CNT_W-1:0] ce_count;

  modport master (
    output btn_mode_n, btn_step_n, rate_sel,
    input  cpu_ce, running, ce_count
  );

  modport slave (
    input  btn_mode_n, btn_step_n, rate_sel,
    output cpu_ce, running, ce_count
  );

endinterface

// File: rtl/cpu_step_controller_debounce.sv
// Button conditioner: 2-flop synchronizer, stability counter and a one-cycle
// press pulse on each accepted transition to the pressed (low) level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DEB_W           = 20
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_press
);

  localparam logic [DEB_W-1:0] CNT_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic             r_level;
  logic             r_press;
  logic [DEB_W-1:0] r_cnt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_press <= 1'b0;
      if (r_sync2 == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // Level accepted; only the transition to pressed is an event.
        r_level <= r_sync2;
        r_cnt   <= '0;
        r_press <= ~r_sync2;
      end else begin
        r_cnt <= r_cnt + DEB_W'(1);
      end
    end
  end

  assign o_press = r_press;

endmodule

// File: rtl/cpu_step_controller.sv
// Run/halt/single-step controller producing a one-cycle cpu_ce pulse in the
// system clock domain, with a run-time selectable free-run rate.
module cpu_step_controller
  import cpu_pkg::*;
#(
  parameter int DIV_WIDTH       = 24,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int DEB_W           = 20,
  parameter bit RESET_RUN       = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_step_controller_if.slave  bus
);

  logic                 w_mode_press;
  logic                 w_step_press;
  logic                 w_frame_end;
  logic [DIV_WIDTH-1:0] w_frame_mask;

  run_state_t           r_state;
  run_state_t           w_state_next;
  logic [DIV_WIDTH-1:0] r_div_cnt;
  logic [DIV_WIDTH-1:0] w_div_next;
  logic [RATE_W-1:0]    r_rate_q;
  logic [RATE_W-1:0]    w_rate_next;
  logic                 r_cpu_ce;
  logic                 w_ce_next;
  logic [CE_CNT_W-1:0]  r_ce_count;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DEB_W           (DEB_W)
  ) u_deb_mode (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_btn_n (bus.btn_mode_n),
    .o_press (w_mode_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .DEB_W           (DEB_W)
  ) u_deb_step (
    .i_clk   (clk),
    .i_rst   (reset),
    .i_btn_n (bus.btn_step_n),
    .o_press (w_step_press)
  );

  // Period is 2^(DIV_WIDTH - 2*rate_q): compare only that many low bits.
  assign w_frame_mask = {DIV_WIDTH{1'b1}} >> {r_rate_q, 1'b0};
  assign w_frame_end  = (r_div_cnt & w_frame_mask) == w_frame_mask;

  always_comb begin
    w_state_next = r_state;
    w_div_next   = r_div_cnt;
    w_rate_next  = r_rate_q;
    w_ce_next    = 1'b0;
    unique case (r_state)
      RUN: begin
        if (w_mode_press) begin
          w_state_next = HALT;
          w_div_next   = '0;
        end else begin
          w_div_next = r_div_cnt + DIV_WIDTH'(1);
          if (w_frame_end) begin
            w_ce_next   = 1'b1;
            w_rate_next = bus.rate_sel;
          end
        end
      end
      HALT: begin
        w_div_next = '0;
        // A simultaneous step is dropped in favour of the mode change.
        if (w_mode_press) begin
          w_state_next = RUN;
          w_rate_next  = bus.rate_sel;
        end else if (w_step_press) begin
          w_ce_next = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= RESET_RUN ? RUN : HALT;
      r_div_cnt  <= '0;
      r_rate_q   <= '0;
      r_cpu_ce   <= 1'b0;
      r_ce_count <= '0;
    end else begin
      r_state    <= w_state_next;
      r_div_cnt  <= w_div_next;
      r_rate_q   <= w_rate_next;
      r_cpu_ce   <= w_ce_next;
      r_ce_count <= r_ce_count + CE_CNT_W'(r_cpu_ce);
    end
  end

  assign bus.cpu_ce   = r_cpu_ce;
  assign bus.running  = (r_state == RUN);
  assign bus.ce_count = r_ce_count;

endmodule

// File: tb/tb_cpu_step_controller.sv
// Directed bench for cpu_step_controller with a short divider and debounce
// window so every timing point can be computed by hand.
module tb_cpu_step_controller;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  cpu_step_controller_if bus();

  cpu_step_controller #(
    .DIV_WIDTH       (8),
    .DEBOUNCE_CYCLES (4),
    .DEB_W           (3),
    .RESET_RUN       (1'b1)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int   cyc    = 0;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   dbl    = 0;
  logic prev_ce = 1'b0;
  int   pulses[$];

  // Posedges since reset release; a pulse registered on posedge k is logged as k.
  always @(posedge clk) if (!reset) cyc++;

  always @(negedge clk) begin
    if (!reset && bus.cpu_ce) begin
      pulses.push_back(cyc);
      if (prev_ce) dbl++;
    end
    prev_ce = bus.cpu_ce;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic run_to(input int c);
    while (cyc < c) tick(1);
  endtask

  function automatic int count_in(input int t0, input int t1);
    int n = 0;
    foreach (pulses[i]) if (pulses[i] > t0 && pulses[i] <= t1) n++;
    return n;
  endfunction

  int c0, e0, c1;
  bit found;

  initial begin
    bus.btn_mode_n = 1'b1;
    bus.btn_step_n = 1'b1;
    bus.rate_sel   = 2'd0;
    tick(3);
    check("rst_cpu_ce",   32'(bus.cpu_ce),   32'd0);
    check("rst_ce_count", 32'(bus.ce_count), 32'd0);
    check("rst_running",  32'(bus.running),  32'd1);
    reset = 1'b0;

    // Free run at rate 0: period 256
    run_to(770);
    check("run_npulse",   32'(pulses.size()), 32'd3);
    check("run_p0",       32'(pulses[0]),     32'd256);
    check("run_p1",       32'(pulses[1]),     32'd512);
    check("run_p2",       32'(pulses[2]),     32'd768);
    check("run_ce_count", 32'(bus.ce_count),  32'd3);

    // Rate change mid-period: current period intact, then period 16
    run_to(868);
    bus.rate_sel = 2'd2;
    run_to(1060);
    check("rate_npulse", 32'(pulses.size()), 32'd6);
    check("rate_p3",     32'(pulses[3]),     32'd1024);
    check("rate_p4",     32'(pulses[4]),     32'd1040);
    check("rate_p5",     32'(pulses[5]),     32'd1056);

    // Halt via mode button
    run_to(1064);
    bus.btn_mode_n = 1'b0;
    tick(6);
    check("halt_edge6_running", 32'(bus.running), 32'd1);
    tick(1);
    check("halt_edge7_running", 32'(bus.running), 32'd0);
    tick(3);
    bus.btn_mode_n = 1'b1;
    tick(40);
    check("halt_npulse",   32'(pulses.size()), 32'd6);
    check("halt_ce_count", 32'(bus.ce_count),  32'd6);

    // Two single steps
    for (int k = 0; k < 2; k++) begin
      c0 = cyc;
      bus.btn_step_n = 1'b0;
      tick(6);
      check("step_edge6_ce", 32'(bus.cpu_ce), 32'd0);
      tick(1);
      check("step_edge7_ce", 32'(bus.cpu_ce), 32'd1);
      tick(1);
      check("step_edge8_ce", 32'(bus.cpu_ce), 32'd0);
      tick(2);
      bus.btn_step_n = 1'b1;
      tick(10);
      check("step_time", 32'(pulses[6 + k]), 32'(c0 + 7));
    end
    check("step_ce_count", 32'(bus.ce_count),  32'd8);
    check("step_npulse",   32'(pulses.size()), 32'd8);

    // Bounce: toggle every 2 cycles for 20 cycles
    for (int i = 0; i < 10; i++) begin
      bus.btn_step_n = ~bus.btn_step_n;
      tick(2);
    end
    tick(10);
    check("bounce_npulse",   32'(pulses.size()), 32'd8);
    check("bounce_ce_count", 32'(bus.ce_count),  32'd8);

    // Mode and step together in HALT: mode wins, rate 2 latched on entry
    bus.btn_mode_n = 1'b0;
    bus.btn_step_n = 1'b0;
    tick(6);
    check("both_edge6_running", 32'(bus.running), 32'd0);
    tick(1);
    check("both_edge7_running", 32'(bus.running), 32'd1);
    check("both_edge7_ce",      32'(bus.cpu_ce),  32'd0);
    e0 = cyc;
    tick(3);
    bus.btn_mode_n = 1'b1;
    bus.btn_step_n = 1'b1;
    run_to(e0 + 15);
    check("both_no_step_pulse", 32'(pulses.size()), 32'd8);
    check("both_ce_before",     32'(bus.cpu_ce),    32'd0);
    tick(1);
    check("both_first_pulse",   32'(bus.cpu_ce),    32'd1);

    // Step in RUN ignored: window holds only the divider pulses e0+48, e0+64
    run_to(e0 + 35);
    c1 = cyc;
    bus.btn_step_n = 1'b0;
    tick(10);
    bus.btn_step_n = 1'b1;
    run_to(e0 + 67);
    check("runstep_window", 32'(count_in(c1, e0 + 67)), 32'd2);
    check("pulse_shape_dbl", 32'(dbl), 32'd0);

    // Counter wrap: preload 0xFFFF in a cycle with no pulse pending
    for (int i = 0; i < 40 && bus.cpu_ce; i++) tick(1);
    force dut.r_ce_count = 16'hFFFF;
    tick(1);
    release dut.r_ce_count;
    check("wrap_preload", 32'(bus.ce_count), 32'h0000_FFFF);
    found = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.cpu_ce) begin
        found = 1'b1;
        break;
      end
      tick(1);
    end
    check("wrap_pulse_seen", 32'(found), 32'd1);
    tick(1);
    check("wrap_ce_count", 32'(bus.ce_count), 32'd0);

    // Async reset while halted with a step pulse in flight
    bus.btn_mode_n = 1'b0;
    tick(10);
    bus.btn_mode_n = 1'b1;
    tick(10);
    check("ar_halted", 32'(bus.running), 32'd0);
    bus.btn_step_n = 1'b0;
    tick(7);
    check("ar_pulse_high", 32'(bus.cpu_ce), 32'd1);
    bus.btn_step_n = 1'b1;
    #1 reset = 1'b1;
    #1;
    check("ar_cpu_ce",   32'(bus.cpu_ce),   32'd0);
    check("ar_running",  32'(bus.running),  32'd1);
    check("ar_ce_count", 32'(bus.ce_count), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
